// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status (12), Cause (13) and EPC (14), plus hardware
// interrupt latching, interrupt request generation, exception entry and ERET return.
module cp0_regfile #(
    parameter int DATA_W     = 32,
    parameter int NUM_HW_INT = 6,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic                  exc_req,
    input  logic [4:0]            exc_code,
    input  logic [DATA_W-1:0]     exc_pc,
    input  logic                  exc_bd,
    input  logic                  eret,
    output logic                  int_req,
    output logic [DATA_W-1:0]     status_out,
    output logic [DATA_W-1:0]     cause_out,
    output logic [DATA_W-1:0]     epc_out
);

    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] ADDR_CAUSE  = ADDR_W'(13);
    localparam logic [ADDR_W-1:0] ADDR_EPC    = ADDR_W'(14);

    // Only the architecturally defined fields are stored; everything else reads 0.
    logic [7:0]            r_im;
    logic                  r_exl;
    logic                  r_ie;
    logic                  r_bd;
    logic [NUM_HW_INT-1:0] r_ip_hw;
    logic [1:0]            r_ip_sw;
    logic [4:0]            r_exc_code;
    logic [DATA_W-1:0]     r_epc;

    logic [5:0]            w_ip_hw6;
    logic [7:0]            w_ip;
    logic [DATA_W-1:0]     w_status;
    logic [DATA_W-1:0]     w_cause;
    logic [DATA_W-1:0]     w_epc_next;

    always_comb begin
        w_ip_hw6                   = '0;
        w_ip_hw6[NUM_HW_INT-1:0]   = r_ip_hw;
    end

    assign w_ip       = {w_ip_hw6, r_ip_sw};
    assign w_status   = {16'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause    = {r_bd, 15'b0, w_ip, 1'b0, r_exc_code, 2'b0};
    // A faulting delay-slot instruction restarts at its branch, one word earlier.
    assign w_epc_next = exc_bd ? (exc_pc - DATA_W'(4)) : exc_pc;

    assign status_out = w_status;
    assign cause_out  = w_cause;
    assign epc_out    = r_epc;
    assign int_req    = r_ie & ~r_exl & (|(w_ip & r_im));

    always_comb begin
        rdata = '0;
        if (raddr == ADDR_STATUS) begin
            rdata = w_status;
        end else if (raddr == ADDR_CAUSE) begin
            rdata = w_cause;
        end else if (raddr == ADDR_EPC) begin
            rdata = r_epc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip_hw    <= '0;
            r_ip_sw    <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else begin
            r_ip_hw <= hw_int;
            if (exc_req) begin
                r_exl      <= 1'b1;
                r_exc_code <= exc_code;
                // A nested exception must not clobber the outer return address.
                if (!r_exl) begin
                    r_bd  <= exc_bd;
                    r_epc <= w_epc_next;
                end
            end else if (eret) begin
                r_exl <= 1'b0;
            end else if (we) begin
                if (waddr == ADDR_STATUS) begin
                    r_im  <= wdata[15:8];
                    r_exl <= wdata[1];
                    r_ie  <= wdata[0];
                end else if (waddr == ADDR_CAUSE) begin
                    r_ip_sw <= wdata[9:8];
                end else if (waddr == ADDR_EPC) begin
                    r_epc <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed vector table walking the key scenarios, then
// randomized traffic checked against a word-level model of the register rules.
module tb_cp0_regfile;
  localparam int DATA_W     = 32;
  localparam int NUM_HW_INT = 6;
  localparam int ADDR_W     = 5;
  localparam int NUM_VEC    = 17;
  localparam int NUM_RAND   = 600;

  logic                  clk;
  logic                  rst;
  logic                  we;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wdata;
  logic [ADDR_W-1:0]     raddr;
  logic [DATA_W-1:0]     rdata;
  logic [NUM_HW_INT-1:0] hw_int;
  logic                  exc_req;
  logic [4:0]            exc_code;
  logic [DATA_W-1:0]     exc_pc;
  logic                  exc_bd;
  logic                  eret;
  logic                  int_req;
  logic [DATA_W-1:0]     status_out;
  logic [DATA_W-1:0]     cause_out;
  logic [DATA_W-1:0]     epc_out;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];

  cp0_regfile #(
    .DATA_W(DATA_W), .NUM_HW_INT(NUM_HW_INT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .hw_int(hw_int), .exc_req(exc_req),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .eret(eret),
    .int_req(int_req), .status_out(status_out), .cause_out(cause_out),
    .epc_out(epc_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  hw;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic        eret;
    logic [31:0] e_status;
    logic [31:0] e_cause;
    logic [31:0] e_epc;
    logic        e_int;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[NUM_VEC];

  // ---------------- reference model (whole-word view) ----------------
  logic [31:0] m_status, m_cause, m_epc;

  function automatic logic m_int();
    return m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] hw_mask;
    hw_mask = ((32'h1 << NUM_HW_INT) - 32'h1) << 10;
    if (rst) begin
      m_status = 32'h0;
      m_cause  = 32'h0;
      m_epc    = 32'h0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ((32'(hw_int) << 10) & hw_mask);
      if (exc_req) begin
        if (!m_status[1]) begin
          m_cause[31] = exc_bd;
          m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        end
        m_status[1] = 1'b1;
        m_cause[6:2] = exc_code;
      end else if (eret) begin
        m_status[1] = 1'b0;
      end else if (we) begin
        case (waddr)
          5'd12: m_status = wdata & 32'h0000_FF03;
          5'd13: m_cause = (m_cause & ~32'h0000_0300) | (wdata & 32'h0000_0300);
          5'd14: m_epc = wdata;
          default: ;
        endcase
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    hw_int = '0; exc_req = 1'b0; exc_code = '0; exc_pc = '0;
    exc_bd = 1'b0; eret = 1'b0;
  endtask

  // Drive at a falling edge, let one rising edge act, check at the next falling edge.
  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata; raddr = v.raddr;
    hw_int = v.hw; exc_req = v.exc; exc_code = v.code; exc_pc = v.pc;
    exc_bd = v.bd; eret = v.eret;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d status", i), status_out, v.e_status);
    chk($sformatf("v%0d cause", i), cause_out, v.e_cause);
    chk($sformatf("v%0d epc", i), epc_out, v.e_epc);
    chk($sformatf("v%0d int_req", i), {31'b0, int_req}, {31'b0, v.e_int});
    chk($sformatf("v%0d rdata", i), rdata, v.e_rdata);
  endtask

  function automatic logic [4:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 5'd12;
      1: return 5'd13;
      2: return 5'd14;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rand_cycle(input int n);
    logic [31:0] r;
    rst = ($urandom_range(0, 59) == 0);
    we = $urandom_range(0, 1) == 1;
    waddr = rand_addr();
    r = $urandom();
    wdata = r;
    raddr = rand_addr();
    if ($urandom_range(0, 3) == 0) hw_int = NUM_HW_INT'($urandom());
    exc_req = ($urandom_range(0, 7) == 0);
    exc_code = 5'($urandom());
    exc_pc = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
    exc_bd = $urandom_range(0, 1) == 1;
    eret = ($urandom_range(0, 6) == 0);
    #1;
    // Pre-edge outputs reflect the state before this cycle's write (no bypass).
    exp_q.push_back(m_read(raddr));
    chk($sformatf("r%0d rdata", n), rdata, exp_q.pop_front());
    chk($sformatf("r%0d status", n), status_out, m_status);
    chk($sformatf("r%0d cause", n), cause_out, m_cause);
    chk($sformatf("r%0d epc", n), epc_out, m_epc);
    chk($sformatf("r%0d int_req", n), {31'b0, int_req}, {31'b0, m_int()});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- main test ----------------
  initial begin
    //            rst we  waddr  wdata          raddr hw     exc code   pc             bd eret  status         cause          epc            int  rdata
    vecs[0]  = '{1'b1,1'b0,5'd0, 32'h0,         5'd12,6'h00,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0,         32'h0,         32'h0,         1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b0,5'd0, 32'h0,         5'd13,6'h00,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0,         32'h0,         32'h0,         1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b1,5'd12,32'hFFFF_FFFF, 5'd12,6'h00,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0000_FF03, 32'h0,         32'h0,         1'b0,32'h0000_FF03};
    vecs[3]  = '{1'b0,1'b1,5'd13,32'hFFFF_FFFF, 5'd13,6'h00,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0000_FF03, 32'h0000_0300, 32'h0,         1'b0,32'h0000_0300};
    vecs[4]  = '{1'b0,1'b1,5'd7, 32'hFFFF_FFFF, 5'd7, 6'h00,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0000_FF03, 32'h0000_0300, 32'h0,         1'b0,32'h0};
    vecs[5]  = '{1'b0,1'b1,5'd12,32'h0000_0401, 5'd12,6'h00,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0000_0401, 32'h0000_0300, 32'h0,         1'b0,32'h0000_0401};
    vecs[6]  = '{1'b0,1'b1,5'd13,32'h0,         5'd13,6'h00,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0000_0401, 32'h0,         32'h0,         1'b0,32'h0};
    vecs[7]  = '{1'b0,1'b0,5'd0, 32'h0,         5'd13,6'h01,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0,         1'b1,32'h0000_0400};
    vecs[8]  = '{1'b0,1'b1,5'd12,32'h0000_0403, 5'd12,6'h01,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0000_0403, 32'h0000_0400, 32'h0,         1'b0,32'h0000_0403};
    vecs[9]  = '{1'b0,1'b1,5'd12,32'h0000_0401, 5'd12,6'h01,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0,         1'b1,32'h0000_0401};
    vecs[10] = '{1'b0,1'b0,5'd0, 32'h0,         5'd14,6'h00,1'b1,5'd4, 32'h0000_3010, 1'b1,1'b0, 32'h0000_0403, 32'h8000_0010, 32'h0000_300C, 1'b0,32'h0000_300C};
    vecs[11] = '{1'b0,1'b0,5'd0, 32'h0,         5'd13,6'h00,1'b1,5'd10,32'h0000_5000, 1'b0,1'b0, 32'h0000_0403, 32'h8000_0028, 32'h0000_300C, 1'b0,32'h8000_0028};
    vecs[12] = '{1'b0,1'b1,5'd14,32'h0000_1234, 5'd14,6'h00,1'b0,5'd0, 32'h0,         1'b0,1'b1, 32'h0000_0401, 32'h8000_0028, 32'h0000_300C, 1'b0,32'h0000_300C};
    vecs[13] = '{1'b0,1'b0,5'd0, 32'h0,         5'd12,6'h00,1'b1,5'd0, 32'h0000_0100, 1'b0,1'b1, 32'h0000_0403, 32'h0,         32'h0000_0100, 1'b0,32'h0000_0403};
    vecs[14] = '{1'b1,1'b1,5'd14,32'hDEAD_BEEF, 5'd13,6'h3F,1'b1,5'd3, 32'h0000_2000, 1'b1,1'b0, 32'h0,         32'h0,         32'h0,         1'b0,32'h0};
    vecs[15] = '{1'b0,1'b0,5'd0, 32'h0,         5'd13,6'h3F,1'b0,5'd0, 32'h0,         1'b0,1'b0, 32'h0,         32'h0000_FC00, 32'h0,         1'b0,32'h0000_FC00};
    vecs[16] = '{1'b0,1'b0,5'd0, 32'h0,         5'd14,6'h3F,1'b1,5'd31,32'h0,         1'b1,1'b0, 32'h0000_0002, 32'h8000_FC7C, 32'hFFFF_FFFC, 1'b0,32'hFFFF_FFFC};

    drive_idle();
    rst = 1'b1;
    m_status = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
    @(negedge clk);
    for (int i = 0; i < NUM_VEC; i++) apply_vec(i);

    // Hand sequence: a write is invisible on the read port until after its edge.
    drive_idle();
    we = 1'b1; waddr = 5'd14; wdata = 32'hCAFE_0001; raddr = 5'd14;
    #1;
    chk("nobypass before", rdata, 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
    chk("nobypass after", rdata, 32'hCAFE_0001);

    // Randomized traffic against the model, started from a known reset.
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int n = 0; n < NUM_RAND; n++) rand_cycle(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
Parametrised coprocessor-0 register file. It supersedes the single write-enabled Cause register and holds Status (reg 12), Cause (reg 13) and EPC (reg 14). It adds hardware interrupt latching, interrupt request generation, exception entry and ERET return. It sits beside the CPU datapath: MTC0/MFC0 use the write and read ports, and the control unit drives the exception and eret inputs.

Parameters:
DATA_W, 32, register width; must be 32 for the MIPS field layout.
NUM_HW_INT, 6, number of hardware interrupt lines; 1..6, mapped to Cause.IP[10 +: NUM_HW_INT].
ADDR_W, 5, CP0 register address width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
we  in  1  MTC0 write enable
waddr  in  ADDR_W  write register number
wdata  in  DATA_W  write data
raddr  in  ADDR_W  read register number
rdata  out  DATA_W  read data, combinational
hw_int  in  NUM_HW_INT  level-sensitive hardware interrupt lines
exc_req  in  1  exception or interrupt being taken this cycle
exc_code  in  5  ExcCode to record
exc_pc  in  DATA_W  PC of the faulting instruction
exc_bd  in  1  faulting instruction is in a branch delay slot
eret  in  1  ERET executing this cycle
int_req  out  1  unmasked interrupt pending
status_out  out  DATA_W  current Status
cause_out  out  DATA_W  current Cause
epc_out  out  DATA_W  current EPC

Behaviour:
- Reset: when rst is high at a clock edge, Status, Cause and EPC all become 0. Consequently int_req=0 and every output reads 0. rst overrides every other input on that edge, including an exception in progress.
- Status layout:
  - IM = bits 15:8, writable.
  - EXL = bit 1, writable.
  - IE = bit 0, writable.
  - All other bits read 0 and ignore writes.
- Cause layout:
  - BD = bit 31.
  - IP[15:10] = hardware lines. Lines beyond NUM_HW_INT read 0.
  - IP[9:8] = software interrupts, writable by MTC0.
  - ExcCode = bits 6:2.
  - All other bits read 0. MTC0 to Cause changes only IP[9:8].
- EPC: full DATA_W, writable by MTC0.
- hw_int is registered into Cause.IP[15:10] on every non-reset edge, whatever we/exc_req/eret are doing. Latency is 1 cycle from hw_int to cause_out and int_req.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM). It is combinational from the registers.
- Exception entry, on an edge with exc_req=1:
  - Always: EXL←1, ExcCode←exc_code.
  - If EXL was 0: BD←exc_bd, and EPC←(exc_bd ? exc_pc-4 : exc_pc), using modulo-2^DATA_W arithmetic.
  - If EXL was already 1 (nested exception): EPC and BD keep their values.
- ERET, on an edge with eret=1 and exc_req=0: EXL←0. All other fields are unchanged.
- Priority on one edge: rst > exc_req > eret > we.
  - A we asserted together with exc_req or eret is discarded entirely.
  - The hw IP update is independent of this priority.
- Write to an address other than 12, 13 or 14 has no effect. Read of any other address returns 0.
- Reads have no write bypass: a read in the same cycle as a write returns the old value. The new value is visible on the cycle after the edge.

Test Plan:
1. Reset and access: hold rst 2 cycles, then write Status=0xFFFF_FFFF → status_out=0x0000_FF03. Write Cause=0xFFFF_FFFF → cause_out=0x0000_0300 (hw_int=0). Read raddr=7 → 0.
2. Interrupt: Status=0x0000_0401, then hw_int=6'b000001 → one cycle later cause_out[10]=1 and int_req=1. Set EXL via write → int_req=0.
3. Exception entry: EXL=0, exc_req with code 5'd4, pc=0x0000_3010, bd=1 → epc_out=0x0000_300C, cause_out[31]=1, cause_out[6:2]=4, status_out[1]=1.
4. Nested exception: with EXL=1, exc_req code 5'd10, pc=0x0000_5000, bd=0 → EPC stays 0x0000_300C, BD stays 1, ExcCode=10.
5. Return and collision: eret together with we to EPC=0x1234 → EXL=0 and EPC unchanged. exc_req together with eret → EXL=1.
6. Mid-operation reset: rst together with exc_req → Status, Cause and EPC all 0, int_req=0.
